// File: rtl/decode_execute_unit_if.sv
// Bus bundle between the decode/execute slice and its surrounding core.
// The core (master) supplies instruction and operands; the slice (slave) returns registered results.
interface decode_execute_unit_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] imm_ext;
    logic [3:0]      alu_control;
    logic            alu_src;
    logic [2:0]      result_src;
    logic [1:0]      pc_src;
    logic [2:0]      instruction_type;
    logic            illegal;

    // No handshake: inputs are sampled every rising edge and every output
    // reflects the inputs of the previous edge.
    modport master (
        output instr, rs1, rs2,
        input  alu_result, imm_ext, alu_control, alu_src,
               result_src, pc_src, instruction_type, illegal
    );

    modport slave (
        input  instr, rs1, rs2,
        output alu_result, imm_ext, alu_control, alu_src,
               result_src, pc_src, instruction_type, illegal
    );
endinterface

// File: rtl/decode_execute_unit.sv
// RV32I decode + immediate extend + ALU slice; all results are registered (1-cycle latency).
// Only XLEN = 32 is supported.
module decode_execute_unit #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_execute_unit_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;
    localparam logic [3:0] ALU_NOP  = 4'd14;

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [2:0] RES_ALU    = 3'd0;
    localparam logic [2:0] RES_IMM    = 3'd1;
    localparam logic [2:0] RES_PC_IMM = 3'd2;
    localparam logic [2:0] RES_PC_4   = 3'd3;
    localparam logic [2:0] RES_MEM    = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_JAL    = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    // Shared funct3 mapping of OP and OP-IMM; 'alt' is funct7[5] where it is honoured.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] branch_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_EQ;
            3'b001:  op = ALU_NE;
            3'b100:  op = ALU_SLT;
            3'b101:  op = ALU_GE;
            3'b110:  op = ALU_SLTU;
            3'b111:  op = ALU_GEU;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic [3:0]      w_alu_control;
    logic            w_alu_src;
    logic [2:0]      w_result_src;
    logic [1:0]      w_pc_src;
    logic [2:0]      w_type;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_ext;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_result;

    assign w_opcode   = bus.instr[6:0];
    assign w_funct3   = bus.instr[14:12];
    assign w_funct7b5 = bus.instr[30];

    always_comb begin
        w_alu_control = ALU_ADD;
        w_alu_src     = 1'b0;
        w_result_src  = RES_ALU;
        w_pc_src      = PC_PLUS4;
        w_type        = TYPE_R;
        w_illegal     = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_alu_control = arith_op(w_funct3, w_funct7b5);
            end
            OPC_OP_IMM: begin
                // Only SRAI looks at funct7[5]; ADDI must never turn into SUB.
                w_type        = TYPE_I;
                w_alu_src     = 1'b1;
                w_alu_control = arith_op(w_funct3, (w_funct3 == 3'b101) && w_funct7b5);
            end
            OPC_LOAD: begin
                w_type       = TYPE_I;
                w_alu_src    = 1'b1;
                w_result_src = RES_MEM;
            end
            OPC_STORE: begin
                w_type    = TYPE_S;
                w_alu_src = 1'b1;
            end
            OPC_BRANCH: begin
                w_type        = TYPE_B;
                w_pc_src      = PC_BRANCH;
                w_alu_control = branch_op(w_funct3);
            end
            OPC_JAL: begin
                w_type       = TYPE_J;
                w_alu_src    = 1'b1;
                w_result_src = RES_PC_4;
                w_pc_src     = PC_JAL;
            end
            OPC_JALR: begin
                w_type       = TYPE_I;
                w_alu_src    = 1'b1;
                w_result_src = RES_PC_4;
                w_pc_src     = PC_JALR;
            end
            OPC_LUI: begin
                w_type       = TYPE_U;
                w_alu_src    = 1'b1;
                w_result_src = RES_IMM;
            end
            OPC_AUIPC: begin
                w_type       = TYPE_U;
                w_alu_src    = 1'b1;
                w_result_src = RES_PC_IMM;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign w_imm_b = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                      bus.instr[11:8], 1'b0};
    assign w_imm_u = {bus.instr[31:12], 12'b0};
    assign w_imm_j = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                      bus.instr[30:21], 1'b0};

    // Illegal opcodes decode as type R, so they pick up the zero immediate too.
    always_comb begin
        w_imm_ext = '0;
        case (w_type)
            TYPE_I:  w_imm_ext = w_imm_i;
            TYPE_S:  w_imm_ext = w_imm_s;
            TYPE_B:  w_imm_ext = w_imm_b;
            TYPE_U:  w_imm_ext = w_imm_u;
            TYPE_J:  w_imm_ext = w_imm_j;
            default: w_imm_ext = '0;
        endcase
    end

    assign w_op1   = bus.rs1;
    assign w_op2   = w_alu_src ? w_imm_ext : bus.rs2;
    assign w_shamt = w_op2[4:0];

    always_comb begin
        w_alu_result = '0;
        case (w_alu_control)
            ALU_ADD:  w_alu_result = w_op1 + w_op2;
            ALU_SUB:  w_alu_result = w_op1 - w_op2;
            ALU_SLL:  w_alu_result = w_op1 << w_shamt;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            ALU_XOR:  w_alu_result = w_op1 ^ w_op2;
            ALU_SRL:  w_alu_result = w_op1 >> w_shamt;
            ALU_SRA:  w_alu_result = $unsigned($signed(w_op1) >>> w_shamt);
            ALU_OR:   w_alu_result = w_op1 | w_op2;
            ALU_AND:  w_alu_result = w_op1 & w_op2;
            ALU_EQ:   w_alu_result = {{(XLEN-1){1'b0}}, w_op1 == w_op2};
            ALU_NE:   w_alu_result = {{(XLEN-1){1'b0}}, w_op1 != w_op2};
            ALU_GE:   w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_op1) >= $signed(w_op2)};
            ALU_GEU:  w_alu_result = {{(XLEN-1){1'b0}}, w_op1 >= w_op2};
            default:  w_alu_result = '0;
        endcase
    end

    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_imm_ext;
    logic [3:0]      r_alu_control;
    logic            r_alu_src;
    logic [2:0]      r_result_src;
    logic [1:0]      r_pc_src;
    logic [2:0]      r_instruction_type;
    logic            r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_result       <= '0;
            r_imm_ext          <= '0;
            r_alu_control      <= '0;
            r_alu_src          <= 1'b0;
            r_result_src       <= '0;
            r_pc_src           <= '0;
            r_instruction_type <= '0;
            r_illegal          <= 1'b0;
        end else begin
            r_alu_result       <= w_alu_result;
            r_imm_ext          <= w_imm_ext;
            r_alu_control      <= w_alu_control;
            r_alu_src          <= w_alu_src;
            r_result_src       <= w_result_src;
            r_pc_src           <= w_pc_src;
            r_instruction_type <= w_type;
            r_illegal          <= w_illegal;
        end
    end

    assign bus.alu_result       = r_alu_result;
    assign bus.imm_ext          = r_imm_ext;
    assign bus.alu_control      = r_alu_control;
    assign bus.alu_src          = r_alu_src;
    assign bus.result_src       = r_result_src;
    assign bus.pc_src           = r_pc_src;
    assign bus.instruction_type = r_instruction_type;
    assign bus.illegal          = r_illegal;
endmodule

// File: tb/tb_decode_execute_unit.sv
// Bench for decode_execute_unit: directed instruction words plus randomized
// instructions/operands checked against an instruction-semantics reference model.
module tb_decode_execute_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] imm;
        logic [3:0]  ctrl;
        logic        asrc;
        logic [2:0]  rsrc;
        logic [1:0]  pcs;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    decode_execute_unit_if #(.XLEN(32)) bus ();

    decode_execute_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: what each RV32I instruction means, computed directly from its fields.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] ii, is, ib, iu, ij, y;
        logic [3:0]  arith_ctrl[8];
        logic [3:0]  br_ctrl[8];
        arith_ctrl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        br_ctrl    = '{4'd10, 4'd11, 4'd14, 4'd14, 4'd3, 4'd12, 4'd4, 4'd13};
        e   = '0;
        f3  = ins[14:12];
        alt = ins[30];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = {ins[31:12], 12'h000};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (ins[6:0])
            7'h33, 7'h13: begin
                if (ins[6:0] == 7'h13) begin
                    e.typ = 3'd1; e.asrc = 1'b1; e.imm = ii; y = ii;
                    if (f3 != 3'd5) alt = 1'b0;
                end else begin
                    y = b;
                end
                e.ctrl = arith_ctrl[f3];
                case (f3)
                    3'd0: begin e.res = alt ? a - y : a + y; if (alt) e.ctrl = 4'd1; end
                    3'd1: e.res = a << y[4:0];
                    3'd2: e.res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: e.res = (a < y) ? 32'd1 : 32'd0;
                    3'd4: e.res = a ^ y;
                    3'd5: begin
                        e.res = alt ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
                        if (alt) e.ctrl = 4'd7;
                    end
                    3'd6: e.res = a | y;
                    default: e.res = a & y;
                endcase
            end
            7'h03: begin e.typ = 3'd1; e.asrc = 1'b1; e.rsrc = 3'd4; e.imm = ii; e.res = a + ii; end
            7'h23: begin e.typ = 3'd2; e.asrc = 1'b1; e.imm = is; e.res = a + is; end
            7'h63: begin
                e.typ = 3'd3; e.pcs = 2'd3; e.imm = ib; e.ctrl = br_ctrl[f3];
                case (f3)
                    3'd0: e.res = 32'(a == b);
                    3'd1: e.res = 32'(a != b);
                    3'd4: e.res = 32'($signed(a) < $signed(b));
                    3'd5: e.res = 32'($signed(a) >= $signed(b));
                    3'd6: e.res = 32'(a < b);
                    3'd7: e.res = 32'(a >= b);
                    default: e.res = 32'd0;
                endcase
            end
            7'h6F: begin e.typ = 3'd5; e.asrc = 1'b1; e.rsrc = 3'd3; e.pcs = 2'd1; e.imm = ij; e.res = a + ij; end
            7'h67: begin e.typ = 3'd1; e.asrc = 1'b1; e.rsrc = 3'd3; e.pcs = 2'd2; e.imm = ii; e.res = a + ii; end
            7'h37: begin e.typ = 3'd4; e.asrc = 1'b1; e.rsrc = 3'd1; e.imm = iu; e.res = a + iu; end
            7'h17: begin e.typ = 3'd4; e.asrc = 1'b1; e.rsrc = 3'd2; e.imm = iu; e.res = a + iu; end
            default: begin e.ill = 1'b1; e.res = a + b; end
        endcase
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_alu_result"}, bus.alu_result, e.res);
        check_eq({tag, "_imm_ext"}, bus.imm_ext, e.imm);
        check_eq({tag, "_alu_control"}, 32'(bus.alu_control), 32'(e.ctrl));
        check_eq({tag, "_alu_src"}, 32'(bus.alu_src), 32'(e.asrc));
        check_eq({tag, "_result_src"}, 32'(bus.result_src), 32'(e.rsrc));
        check_eq({tag, "_pc_src"}, 32'(bus.pc_src), 32'(e.pcs));
        check_eq({tag, "_type"}, 32'(bus.instruction_type), 32'(e.typ));
        check_eq({tag, "_illegal"}, 32'(bus.illegal), 32'(e.ill));
    endtask

    // Drive one instruction, let one edge pass, then compare the registered outputs.
    task automatic run_one(input string tag, input logic rst, input logic [31:0] ins,
                           input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset     = rst;
        bus.instr = ins;
        bus.rs1   = a;
        bus.rs2   = b;
        exp_q.push_back(rst ? exp_t'('0) : model(ins, a, b));
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    logic [6:0] legal_ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    initial begin
        logic [31:0] ins, a, b;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.instr = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        repeat (2) @(posedge clk);

        run_one("reset", 1'b1, 32'hFFF00093, 32'h1234, 32'h5678);
        run_one("addi_after_reset", 1'b0, 32'hFFF00093, 32'd0, 32'd0);
        check_eq("addi_imm_const", bus.imm_ext, 32'hFFFFFFFF);

        run_one("add", 1'b0, 32'h002081B3, 32'd5, 32'd7);
        check_eq("add_const", bus.alu_result, 32'd12);
        run_one("sub", 1'b0, 32'h402081B3, 32'd3, 32'd5);
        check_eq("sub_const", bus.alu_result, 32'hFFFFFFFE);
        run_one("srai", 1'b0, 32'h4040D093, 32'h80000000, 32'd0);
        check_eq("srai_const", bus.alu_result, 32'hF8000000);
        run_one("beq_taken", 1'b0, 32'hFE208CE3, 32'd9, 32'd9);
        check_eq("beq_imm_const", bus.imm_ext, 32'hFFFFFFF8);
        check_eq("beq_taken_const", bus.alu_result, 32'd1);
        run_one("beq_not_taken", 1'b0, 32'hFE208CE3, 32'd9, 32'd10);
        check_eq("beq_nt_const", bus.alu_result, 32'd0);
        run_one("lui", 1'b0, 32'h123452B7, 32'd0, 32'd0);
        check_eq("lui_imm_const", bus.imm_ext, 32'h12345000);
        run_one("jal", 1'b0, 32'h008000EF, 32'd0, 32'd0);
        check_eq("jal_pc_src_const", 32'(bus.pc_src), 32'd1);
        run_one("sw", 1'b0, 32'h0020A223, 32'h100, 32'd0);
        check_eq("sw_res_const", bus.alu_result, 32'h104);
        run_one("illegal", 1'b0, 32'h0000007F, 32'd1, 32'd2);
        check_eq("illegal_const", 32'(bus.illegal), 32'd1);
        run_one("illegal_clear", 1'b0, 32'h002081B3, 32'd1, 32'd2);
        run_one("addi_not_sub", 1'b0, 32'h40108093, 32'd10, 32'd0);
        run_one("blt_reserved_f3", 1'b0, 32'h0020A063, 32'd1, 32'd1);

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0)
                ins[6:0] = legal_ops[$urandom_range(0, 8)];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            run_one("rand", ($urandom_range(0, 49) == 0), ins, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_execute_unit.md
Name: decode_execute_unit

Overview:
- Registered RV32I decode-and-execute slice for the single-cycle/multi-cycle core.
- Contains three functions:
  - the main decoder, which turns the opcode, funct3 and funct7[5] into datapath controls;
  - the immediate extender;
  - the ALU, which operates on rs1 and on either rs2 or the immediate.
- The register file supplies rs1/rs2 and the instruction register supplies the instruction.
- All results are presented one clock later, to the result mux and the PC selector.

Parameters:
- XLEN, 32, datapath width. Only the value 32 is supported.

Ports:
- clk  input  1  Rising-edge clock.
- reset  input  1  Synchronous, active-high reset.
- instr  input  32  Instruction word.
- rs1  input  32  Register-file read data 1.
- rs2  input  32  Register-file read data 2.
- alu_result  output  32  Registered ALU output.
- imm_ext  output  32  Registered sign-extended immediate.
- alu_control  output  4  Registered ALU operation code.
- alu_src  output  1  Registered operand-2 select: 1 = imm_ext, 0 = rs2.
- result_src  output  3  Registered writeback select: 0 = ALU, 1 = imm, 2 = pc+imm, 3 = pc+4, 4 = memory.
- pc_src  output  2  Registered next-PC select: 0 = pc+4, 1 = pc+imm, 2 = rs1+imm, 3 = branch (pc+imm if alu_result[0], else pc+4).
- instruction_type  output  3  Registered format: 0 = R, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J.
- illegal  output  1  Registered flag for an unsupported opcode.

Behaviour:
- Timing:
  - All logic is combinational from instr/rs1/rs2.
  - Every output is a flop updated on the rising edge of clk, so latency is 1 cycle.
  - Inputs change freely; there is no handshake.
- Reset:
  - When reset is high at an edge, all outputs load 0. This includes illegal = 0.
  - Reset has priority over new data; reset mid-stream simply discards the pending decode.
- alu_control encodings:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA.
  - 8 OR, 9 AND, 10 EQ, 11 NE, 12 GE (signed), 13 GEU.
  - Codes 14 and 15 produce 0.
  - Comparison results are 0 or 1.
  - Shifts use operand2[4:0] only.
  - Add and subtract wrap modulo 2^32.
- ALU operands: operand1 = rs1; operand2 = alu_src ? imm : rs2, using this cycle's decode.
- Immediates (result is 0 for the R type and for illegal opcodes):
  - I: sign-extended instr[31:20].
  - S: sign-extended {instr[31:25], instr[11:7]}.
  - B: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Decode by opcode:
  - OP (0110011):
    - type R, alu_src 0, result_src 0, pc_src 0.
    - funct3 selects the op: 000 ADD, or SUB when funct7[5] = 1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5] = 1; 110 OR; 111 AND.
  - OP-IMM (0010011):
    - type I, alu_src 1, result_src 0, pc_src 0.
    - Same funct3 mapping as OP, except funct7[5] is honoured only for 101 (SRAI). ADDI never becomes SUB.
  - LOAD (0000011): type I, ADD, alu_src 1, result_src 4, pc_src 0.
  - STORE (0100011): type S, ADD, alu_src 1, result_src 0, pc_src 0.
  - BRANCH (1100011):
    - type B, alu_src 0, result_src 0, pc_src 3.
    - funct3 selects the comparison: 000 EQ, 001 NE, 100 SLT, 101 GE, 110 SLTU, 111 GEU.
    - funct3 010 and 011 use code 14, so alu_result = 0 and the branch is never taken.
  - JAL (1101111): type J, ADD, alu_src 1, result_src 3, pc_src 1.
  - JALR (1100111): type I, ADD, alu_src 1, result_src 3, pc_src 2.
  - LUI (0110111): type U, ADD, alu_src 1, result_src 1, pc_src 0.
  - AUIPC (0010111): type U, ADD, alu_src 1, result_src 2, pc_src 0.
  - Any other opcode:
    - illegal = 1, type R, imm 0, ADD, alu_src 0, result_src 0, pc_src 0.
    - alu_result = rs1 + rs2.

Test Plan:
- Reset: assert reset with instr = 0xFFF00093 → after the edge all outputs are 0; deassert → the next edge shows the decode.
- ADD/SUB: instr 0x002081B3, rs1 = 5, rs2 = 7 → alu_result 12, alu_control 0, alu_src 0, type 0. Then instr 0x402081B3, rs1 = 3, rs2 = 5 → alu_result 0xFFFFFFFE, alu_control 1.
- Immediate forms:
  - 0xFFF00093 (addi), rs1 = 0 → imm_ext 0xFFFFFFFF, alu_result 0xFFFFFFFF, alu_src 1, type 1.
  - 0x4040D093 (srai 4), rs1 = 0x80000000 → alu_result 0xF8000000, alu_control 7.
- Branch: 0xFE208CE3 (beq, −8), rs1 = rs2 = 9 → imm_ext 0xFFFFFFF8, pc_src 3, type 3, alu_control 10, alu_result 1. With rs2 = 10 → alu_result 0.
- Upper/jump/store:
  - 0x123452B7 (lui) → imm_ext 0x12345000, result_src 1, type 4.
  - A JAL word → pc_src 1, result_src 3, type 5.
  - 0x0020A223 (sw x2, 4(x1)), rs1 = 0x100 → imm_ext 4, alu_result 0x104, type 2.
- Illegal: instr 0x0000007F, rs1 = 1, rs2 = 2 → illegal 1, alu_result 3, imm_ext 0. The next legal instruction clears illegal.
